ysyx_22050019_axi_rd_arbiter: RTL and testbench

//  Shares the single AXI4-Lite-style read port to memory between the IFU (instruction fetch) and the LSU (loads).

---
 rtl/ysyx_22050019_axi_rd_arbiter.sv | 136 +++++++++++++
 tb/tb_ysyx_22050019_axi_rd_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Two-master (IFU/LSU) arbiter for a single AXI4-Lite-style read port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise LSU wins every tie.
module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic              arb_busy_o,
  output logic              arb_grant_o
);

  typedef enum logic [2:0] {
    IDLE,
    AR_IFU,
    R_IFU,
    AR_LSU,
    R_LSU
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   tie_pick_lsu;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_lsu = ~last_grant;
`else
  assign tie_pick_lsu = 1'b1;
`endif

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    ifu_arready     = 1'b0;
    ifu_rdata       = '0;
    ifu_rresp       = 2'b00;
    ifu_rvalid      = 1'b0;
    lsu_arready     = 1'b0;
    lsu_rdata       = '0;
    lsu_rresp       = 2'b00;
    lsu_rvalid      = 1'b0;
    mem_araddr      = '0;
    mem_arvalid     = 1'b0;
    mem_rready      = 1'b0;

    case (state)
      IDLE: begin
        if (ifu_arvalid && lsu_arvalid) begin
          state_next = tie_pick_lsu ? AR_LSU : AR_IFU;
        end else if (lsu_arvalid) begin
          state_next = AR_LSU;
        end else if (ifu_arvalid) begin
          state_next = AR_IFU;
        end
      end
      AR_IFU: begin
        mem_araddr  = ifu_araddr;
        mem_arvalid = ifu_arvalid;
        ifu_arready = mem_arready;
        // A requester that withdraws before the handshake releases the port.
        if (ifu_arvalid && mem_arready) begin
          state_next = R_IFU;
        end else if (!ifu_arvalid) begin
          state_next = IDLE;
        end
      end
      R_IFU: begin
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
        ifu_rvalid = mem_rvalid;
        mem_rready = ifu_rready;
        if (mem_rvalid && ifu_rready) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end
      end
      AR_LSU: begin
        mem_araddr  = lsu_araddr;
        mem_arvalid = lsu_arvalid;
        lsu_arready = mem_arready;
        if (lsu_arvalid && mem_arready) begin
          state_next = R_LSU;
        end else if (!lsu_arvalid) begin
          state_next = IDLE;
        end
      end
      R_LSU: begin
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
        lsu_rvalid = mem_rvalid;
        mem_rready = lsu_rready;
        if (mem_rvalid && lsu_rready) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign arb_busy_o  = (state != IDLE);
  assign arb_grant_o = (state == AR_LSU) || (state == R_LSU);

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Bench for ysyx_22050019_axi_rd_arbiter: directed scenarios plus randomized traffic against
// a transaction-level ownership model. Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_ysyx_22050019_axi_rd_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int OUT_W  = 2 * (DATA_W + 4) + ADDR_W + 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ifu_araddr, lsu_araddr, mem_araddr;
  logic              ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic              lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [DATA_W-1:0] ifu_rdata, lsu_rdata, mem_rdata;
  logic [1:0]        ifu_rresp, lsu_rresp, mem_rresp;
  logic              mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic              arb_busy_o, arb_grant_o;
  logic [OUT_W-1:0]  all_outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .arb_busy_o(arb_busy_o), .arb_grant_o(arb_grant_o)
  );

  assign all_outs = {ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
                     lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                     mem_araddr, mem_arvalid, mem_rready, arb_busy_o, arb_grant_o};

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, a[31:0] + 32'h1357_9BDF};
  endfunction

  function automatic logic [1:0] mem_resp(input logic [ADDR_W-1:0] a);
    return a[4:3];
  endfunction

  // 1 = LSU wins a simultaneous request, given who completed last.
  function automatic logic tie_winner(input logic last);
    return RR_MODE ? ~last : 1'b1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    mem_arready = 1'b0; mem_rdata = '0; mem_rresp = 2'b00; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; mem_arready = 1'b1; mem_rvalid = 1'b1;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    ifu_araddr = 64'h8000_0000; lsu_araddr = 64'h8000_1000;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D; mem_rresp = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_outs !== '0) $display("[TB] FAIL reset_outs: got %h required 0", all_outs);
    if (all_outs !== '0) bad++;
    next_cycle();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %h required 0", all_outs);
    end
    next_cycle();
  endtask

  task automatic test_ifu_only();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    a = 64'h8000_0000;
    d = 64'h1111_2222_3333_4444;
    ifu_araddr = a; ifu_arvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0 || ifu_arready !== 1'b0 || mem_arvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ifu_arb_latency: busy=%b arready=%b mem_arvalid=%b required 0 0 0",
               arb_busy_o, ifu_arready, mem_arvalid);
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({arb_busy_o, arb_grant_o, mem_arvalid, ifu_arready} !== 4'b1010 || mem_araddr !== a) begin
        bad++;
        $display("[TB] FAIL ifu_ar_wait: busy/grant/arvalid/arready=%b addr=%h required 1010 %h",
                 {arb_busy_o, arb_grant_o, mem_arvalid, ifu_arready}, mem_araddr, a);
      end
      next_cycle();
    end
    mem_arready = 1'b1;
    @(negedge clk);
    total++;
    if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ifu_arready: got ifu=%b lsu=%b required 1 0", ifu_arready, lsu_arready);
    end
    next_cycle();
    ifu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = d; mem_rresp = 2'b00;
    @(negedge clk);
    total++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== d || lsu_rvalid !== 1'b0 || mem_rready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ifu_rbeat: rvalid=%b data=%h lsu_rvalid=%b mem_rready=%b required 1 %h 0 1",
               ifu_rvalid, ifu_rdata, lsu_rvalid, mem_rready, d);
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0 || mem_araddr !== '0 || ifu_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ifu_back_idle: busy=%b addr=%h rvalid=%b required 0 0 0",
               arb_busy_o, mem_araddr, ifu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_tie();
    logic              last, win;
    logic [ADDR_W-1:0] ia, la, wa;
    rst_n = 1'b1;
    clear_inputs();
    next_cycle();
    rst_n = 1'b0;
    last = 1'b0;
    ia = 64'h8000_0004;
    la = 64'h8000_1000;
    ifu_araddr = ia; lsu_araddr = la;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      // Last round leaves only IFU requesting.
      if (r == 4) lsu_arvalid = 1'b0;
      win = (r == 4) ? 1'b0 : tie_winner(last);
      wa  = win ? la : ia;
      next_cycle();
      mem_arready = 1'b1;
      @(negedge clk);
      total++;
      if (arb_grant_o !== win || mem_araddr !== wa || mem_arvalid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL tie_grant r%0d: grant=%b addr=%h arvalid=%b required %b %h 1",
                 r, arb_grant_o, mem_araddr, mem_arvalid, win, wa);
      end
      total++;
      if ((win ? ifu_arready : lsu_arready) !== 1'b0) begin
        bad++;
        $display("[TB] FAIL tie_loser_arready r%0d: got 1 required 0", r);
      end
      next_cycle();
      mem_arready = 1'b0;
      if (win) lsu_arvalid = 1'b0;
      else     ifu_arvalid = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = mem_data(wa); mem_rresp = mem_resp(wa);
      @(negedge clk);
      total++;
      if ((win ? lsu_rvalid : ifu_rvalid) !== 1'b1 || (win ? lsu_rdata : ifu_rdata) !== mem_data(wa) ||
          (win ? ifu_rvalid : lsu_rvalid) !== 1'b0) begin
        bad++;
        $display("[TB] FAIL tie_route r%0d: ifu_rvalid=%b lsu_rvalid=%b data=%h required winner=%b data=%h",
                 r, ifu_rvalid, lsu_rvalid, win ? lsu_rdata : ifu_rdata, win, mem_data(wa));
      end
      next_cycle();
      mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;
      last = win;
      if (win) begin
        la = la + 64'h8; lsu_araddr = la; lsu_arvalid = 1'b1;
      end else begin
        ia = ia + 64'h8; ifu_araddr = ia; ifu_arvalid = 1'b1;
      end
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tie_end_idle: busy=%b required 0", arb_busy_o);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    a = 64'h8000_2000;
    d = mem_data(a);
    lsu_araddr = a; lsu_arvalid = 1'b1; lsu_rready = 1'b0; mem_arready = 1'b1;
    ifu_araddr = 64'h8000_0100; ifu_rready = 1'b1;
    next_cycle();
    ifu_arvalid = 1'b1;
    @(negedge clk);
    total++;
    if (arb_grant_o !== 1'b1 || lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_ar: grant=%b lsu_arready=%b ifu_arready=%b required 1 1 0",
               arb_grant_o, lsu_arready, ifu_arready);
    end
    next_cycle();
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = d; mem_rresp = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({mem_rready, arb_busy_o, arb_grant_o, lsu_rvalid, ifu_arready} !== 5'b01110 || lsu_rdata !== d) begin
        bad++;
        $display("[TB] FAIL bp_hold c%0d: rready/busy/grant/rvalid/ifu_arready=%b data=%h required 01110 %h",
                 i, {mem_rready, arb_busy_o, arb_grant_o, lsu_rvalid, ifu_arready}, lsu_rdata, d);
      end
      next_cycle();
    end
    lsu_rready = 1'b1;
    @(negedge clk);
    total++;
    if (mem_rready !== 1'b1 || ifu_arready !== 1'b0 || lsu_rresp !== 2'b01) begin
      bad++;
      $display("[TB] FAIL bp_release: mem_rready=%b ifu_arready=%b rresp=%b required 1 0 01",
               mem_rready, ifu_arready, lsu_rresp);
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00; ifu_arvalid = 1'b0;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0 || lsu_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_done: busy=%b lsu_rvalid=%b required 0 0", arb_busy_o, lsu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_abort();
    ifu_araddr = 64'h8000_0200; ifu_arvalid = 1'b1; mem_arready = 1'b0; ifu_rready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (mem_arvalid !== 1'b1 || arb_grant_o !== 1'b0 || arb_busy_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_ar: arvalid=%b grant=%b busy=%b required 1 0 1",
               mem_arvalid, arb_grant_o, arb_busy_o);
    end
    next_cycle();
    ifu_arvalid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_arvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_drop: mem_arvalid=%b required 0", mem_arvalid);
    end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0 || ifu_rvalid !== 1'b0 || mem_rready !== 1'b0 || ifu_rdata !== '0) begin
      bad++;
      $display("[TB] FAIL abort_no_r: busy=%b rvalid=%b mem_rready=%b data=%h required 0 0 0 0",
               arb_busy_o, ifu_rvalid, mem_rready, ifu_rdata);
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] a;
    ifu_araddr = 64'h8000_0300; ifu_arvalid = 1'b1; mem_arready = 1'b1; ifu_rready = 1'b0;
    next_cycle();
    next_cycle();
    ifu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD; mem_rresp = 2'b10;
    @(negedge clk);
    total++;
    if (ifu_rvalid !== 1'b1 || ifu_rresp !== 2'b10) begin
      bad++;
      $display("[TB] FAIL rstmid_pre: rvalid=%b rresp=%b required 1 10", ifu_rvalid, ifu_rresp);
    end
    next_cycle();
    rst_n = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;
    next_cycle();
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("[TB] FAIL rstmid_outs: got %h required 0", all_outs);
    end
    next_cycle();
    rst_n = 1'b0;
    a = 64'h8000_0400;
    ifu_araddr = a; ifu_arvalid = 1'b1; ifu_rready = 1'b1; mem_arready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (mem_araddr !== a || ifu_arready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstmid_ar: addr=%h arready=%b required %h 1", mem_araddr, ifu_arready, a);
    end
    next_cycle();
    ifu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = mem_data(a); mem_rresp = 2'b00;
    @(negedge clk);
    total++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== mem_data(a) || ifu_rresp !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rstmid_r: rvalid=%b data=%h rresp=%b required 1 %h 00",
               ifu_rvalid, ifu_rdata, ifu_rresp, mem_data(a));
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    total++;
    if (arb_busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_done: busy=%b required 0", arb_busy_o);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic              i_pend, i_wait, l_pend, l_wait;
    logic [ADDR_W-1:0] i_addr, l_addr, own_addr, m_addr;
    logic              own_valid, own_lsu, last, o_rvalid, o_rready;
    logic [DATA_W-1:0] o_rdata;
    logic [1:0]        o_rresp;
    logic [DATA_W+3:0] loser;
    int                m_st, m_dly, done_cnt, stall;
    rst_n = 1'b1;
    clear_inputs();
    next_cycle();
    rst_n = 1'b0;
    i_pend = 1'b0; i_wait = 1'b0; l_pend = 1'b0; l_wait = 1'b0;
    i_addr = '0; l_addr = '0; own_addr = '0; m_addr = '0;
    own_valid = 1'b0; own_lsu = 1'b0; last = 1'b0;
    m_st = 0; m_dly = 0; done_cnt = 0; stall = 0;
    for (int c = 0; c < 800; c++) begin
      if (!i_pend && !i_wait && $urandom_range(2) == 0) begin
        i_pend = 1'b1;
        i_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h00FF_FFF8)};
      end
      if (!l_pend && !l_wait && $urandom_range(2) == 0) begin
        l_pend = 1'b1;
        l_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h00FF_FFF8)};
      end
      ifu_arvalid = i_pend; ifu_araddr = i_addr; ifu_rready = 1'($urandom_range(1));
      lsu_arvalid = l_pend; lsu_araddr = l_addr; lsu_rready = 1'($urandom_range(1));
      mem_arready = (m_st == 0) ? 1'($urandom_range(1)) : 1'b0;
      mem_rvalid  = (m_st == 2);
      mem_rdata   = (m_st == 2) ? mem_data(m_addr) : '0;
      mem_rresp   = (m_st == 2) ? mem_resp(m_addr) : 2'b00;
      @(negedge clk);
      if (!own_valid) begin
        total++;
        if (all_outs !== '0) begin
          bad++;
          $display("[TB] FAIL rand_idle c%0d: outs=%h required 0", c, all_outs);
        end
        if (ifu_arvalid || lsu_arvalid) begin
          own_valid = 1'b1;
          own_lsu   = (ifu_arvalid && lsu_arvalid) ? tie_winner(last) : lsu_arvalid;
          own_addr  = own_lsu ? l_addr : i_addr;
        end
      end else begin
        loser    = own_lsu ? {ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp}
                           : {lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp};
        o_rvalid = own_lsu ? lsu_rvalid : ifu_rvalid;
        o_rready = own_lsu ? lsu_rready : ifu_rready;
        o_rdata  = own_lsu ? lsu_rdata  : ifu_rdata;
        o_rresp  = own_lsu ? lsu_rresp  : ifu_rresp;
        total++;
        if (arb_busy_o !== 1'b1 || arb_grant_o !== own_lsu || loser !== '0) begin
          bad++;
          $display("[TB] FAIL rand_owner c%0d: busy=%b grant=%b loser=%h required 1 %b 0",
                   c, arb_busy_o, arb_grant_o, loser, own_lsu);
        end
        if (mem_arvalid) begin
          total++;
          if (mem_araddr !== own_addr) begin
            bad++;
            $display("[TB] FAIL rand_araddr c%0d: got %h required %h", c, mem_araddr, own_addr);
          end
        end
        if (o_rvalid) begin
          total++;
          if (o_rdata !== mem_data(own_addr) || o_rresp !== mem_resp(own_addr)) begin
            bad++;
            $display("[TB] FAIL rand_rdata c%0d: got %h/%b required %h/%b",
                     c, o_rdata, o_rresp, mem_data(own_addr), mem_resp(own_addr));
          end
        end
        if (o_rvalid && o_rready) begin
          last      = own_lsu;
          own_valid = 1'b0;
        end
      end
      if (ifu_arvalid && ifu_arready) begin i_pend = 1'b0; i_wait = 1'b1; end
      if (ifu_rvalid && ifu_rready) i_wait = 1'b0;
      if (lsu_arvalid && lsu_arready) begin l_pend = 1'b0; l_wait = 1'b1; end
      if (lsu_rvalid && lsu_rready) l_wait = 1'b0;
      if ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready)) begin
        done_cnt++;
        stall = 0;
      end else begin
        stall++;
      end
      case (m_st)
        0: if (mem_arvalid && mem_arready) begin
             m_addr = mem_araddr;
             m_dly  = int'($urandom_range(3));
             m_st   = 1;
           end
        1: if (m_dly == 0) m_st = 2; else m_dly--;
        default: if (mem_rready) m_st = 0;
      endcase
      if (stall > 60) begin
        total++;
        bad++;
        $display("[TB] FAIL rand_timeout c%0d: no completion for %0d cycles required <= 60", c, stall);
        break;
      end
      next_cycle();
    end
    total++;
    if (done_cnt < 20) begin
      bad++;
      $display("[TB] FAIL rand_progress: completed %0d required >= 20", done_cnt);
    end
    rst_n = 1'b1;
    clear_inputs();
    next_cycle();
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_ifu_only();
    test_tie();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
